// File: rtl/alu_pkg.sv
// Shared ALUControl code table and execute-unit state encoding.
// Imported by both the ALU control decoder and the execute unit.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_BGEZ = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BGTZ = 4'd12;
    localparam logic [3:0] ALU_BLEZ = 4'd13;
    localparam logic [3:0] ALU_BLTZ = 4'd14;
    localparam logic [3:0] ALU_RSVD = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Branch codes report their condition on Zero and force the result to 0.
    function automatic logic is_branch(input logic [3:0] code);
        return (code >= ALU_BGEZ) && (code <= ALU_BLTZ);
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits only.
// o_done pulses for one cycle with o_product final.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_product;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand   <= i_a;
                r_mplier  <= i_b;
                r_product <= '0;
                r_count   <= '0;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_product <= r_product + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CNT_W'(1);
                // Last iteration retires here; product is final when done pulses.
                if (r_count == CNT_W'(MUL_CYCLES - 1)) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_count <= '0;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops plus iterative multiply.
// Results and Zero are registered and held until the consumer takes them.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy
);

    alu_state_e       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_result;
    logic             w_branch;
    logic             w_zero;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && OutReady);
    assign w_accept   = InValid && w_in_ready;
    assign w_is_mul   = (ALUControl == ALU_MUL);

    // Single-cycle datapath; multiply result comes from the engine instead.
    always_comb begin
        w_result = '0;
        w_branch = 1'b0;
        case (ALUControl)
            ALU_ADD:  w_result = A + B;
            ALU_SUB:  w_result = A - B;
            ALU_AND:  w_result = A & B;
            ALU_OR:   w_result = A | B;
            ALU_NOR:  w_result = ~(A | B);
            ALU_XOR:  w_result = A ^ B;
            ALU_SLL:  w_result = B << Shamt;
            ALU_SRL:  w_result = B >> Shamt;
            ALU_SLT:  w_result = WIDTH'($signed(A) < $signed(B));
            ALU_BGEZ: w_branch = !A[WIDTH-1];
            ALU_BNE:  w_branch = (A != B);
            ALU_BGTZ: w_branch = !A[WIDTH-1] && (A != '0);
            ALU_BLEZ: w_branch = A[WIDTH-1] || (A == '0);
            ALU_BLTZ: w_branch = A[WIDTH-1];
            default:  w_result = '0;
        endcase
    end

    assign w_zero = is_branch(ALUControl) ? w_branch
                  : (ALUControl == ALU_RSVD) ? 1'b0
                  : (w_result == '0);

    alu_mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_start   (w_accept && w_is_mul),
        .i_a       (A),
        .i_b       (B),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Handshake FSM and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= MUL;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_result;
                            r_zero      <= w_zero;
                        end
                    end else if ((r_state == DONE) && OutReady) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_product;
                        r_zero      <= (w_mul_product == '0);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign InReady   = w_in_ready;
    assign OutValid  = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Busy      = w_mul_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard,
// plus hand-written multiply, backpressure and reset sequences.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned MULC  = 32;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             InValid;
    logic             InReady;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       Shamt;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb_q[$];

    alu_exec_unit #(.WIDTH(WIDTH), .MUL_CYCLES(MULC)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Shamt      (Shamt),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] s, input logic [31:0] r, input logic z);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.sh = s; v.res = r; v.z = z;
        return v;
    endfunction

    // Drive one op (caller is just after a posedge); expected result goes to the scoreboard.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] er, input logic ez);
        int n;
        n = 0;
        ALUControl = c; A = a; B = b; Shamt = s; InValid = 1'b1;
        @(negedge Clk);
        while (!InReady && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("send_ready", 32'(InReady), 32'd1);
        sb_q.push_back({er, ez});
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    // Scoreboard side: compare whenever a result is handed off.
    always @(negedge Clk) begin
        if (!Reset && OutValid && OutReady) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", ALUResult, 32'hDEAD_BEEF);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("result", ALUResult, e[32:1]);
                check("zero", 32'(Zero), 32'(e[0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int busy_cnt;
        int ready_bad;
        int spur;
        int n;
        logic [31:0] ma;
        logic [31:0] mb;

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        ALUControl = '0; A = '0; B = '0; Shamt = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        @(posedge Clk); #1;

        // Latency: result visible one cycle after accept.
        send(4'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
        @(negedge Clk);
        check("lat1_outvalid", 32'(OutValid), 32'd1);
        check("lat1_result", ALUResult, 32'd12);
        @(posedge Clk); #1;

        vecs.push_back(mk(4'd1,  32'h0000_1234, 32'h0000_1234, 5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd9,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,          1'b0));
        vecs.push_back(mk(4'd6,  32'h0,         32'h1,         5'd31, 32'h8000_0000,  1'b0));
        vecs.push_back(mk(4'd7,  32'h0,         32'h8000_0000, 5'd31, 32'h1,          1'b0));
        vecs.push_back(mk(4'd10, 32'h0,         32'h5,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd12, 32'h0,         32'h5,         5'd0,  32'h0,          1'b0));
        vecs.push_back(mk(4'd13, 32'h0,         32'h5,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd14, 32'h0,         32'h5,         5'd0,  32'h0,          1'b0));
        vecs.push_back(mk(4'd11, 32'h3,         32'h4,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd2,  32'hF0F0_FFFF, 32'h0FF0_F00F, 5'd0,  32'h00F0_F00F,  1'b0));
        vecs.push_back(mk(4'd3,  32'h0000_0F00, 32'h0000_00F0, 5'd0,  32'h0000_0FF0,  1'b0));
        vecs.push_back(mk(4'd4,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF,  1'b0));
        vecs.push_back(mk(4'd5,  32'hAAAA_5555, 32'hAAAA_5555, 5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd0,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd15, 32'h1,         32'h2,         5'd0,  32'h0,          1'b0));
        vecs.push_back(mk(4'd14, 32'h8000_0000, 32'h0,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd12, 32'h1,         32'h0,         5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd1,  32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF,  1'b0));
        vecs.push_back(mk(4'd9,  32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0,          1'b1));
        vecs.push_back(mk(4'd11, 32'h7,         32'h7,         5'd0,  32'h0,          1'b0));

        // Back-to-back issue with OutReady high: one op per clock.
        foreach (vecs[i]) begin
            send(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res, vecs[i].z);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("drain_table", 32'(sb_q.size()), 32'd0);
        @(posedge Clk); #1;

        // Multiply -3 * 7: Busy 32 cycles, InReady low until the result.
        send(4'd8, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'hFFFF_FFEB, 1'b0);
        k = 0; busy_cnt = 0; ready_bad = 0;
        do begin
            @(negedge Clk);
            k++;
            if (Busy) busy_cnt++;
            if (!OutValid && InReady) ready_bad++;
        end while (!OutValid && k < 100);
        check("mul_latency", 32'(k), 32'(MULC + 2));
        check("mul_busy_cycles", 32'(busy_cnt), 32'(MULC));
        check("mul_inready_low", 32'(ready_bad), 32'd0);
        @(posedge Clk); #1;

        ma = 32'h1234_5678; mb = 32'h9ABC_DEF0;
        send(4'd8, ma, mb, 5'd0, ma * mb, (ma * mb) == 32'h0);
        ma = 32'h0001_0000; mb = 32'h0001_0000;
        send(4'd8, ma, mb, 5'd0, 32'h0, 1'b1);
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("drain_mul", 32'(sb_q.size()), 32'd0);
        @(posedge Clk); #1;

        // Backpressure: result held, no capture while the consumer stalls.
        OutReady = 1'b0;
        send(4'd0, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);
        ALUControl = 4'd1; A = 32'd1; B = 32'd1; InValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("hold_valid", 32'(OutValid), 32'd1);
            check("hold_result", ALUResult, 32'd30);
            check("hold_zero", 32'(Zero), 32'd0);
            check("hold_inready", 32'(InReady), 32'd0);
        end
        @(posedge Clk); #1;
        InValid = 1'b0; OutReady = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("drain_hold", 32'(sb_q.size()), 32'd0);
        @(posedge Clk); #1;

        // Reset at iteration 10 of a multiply: no partial result escapes.
        send(4'd8, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0);
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        sb_q.delete();
        @(negedge Clk);
        check("mrst_outvalid", 32'(OutValid), 32'd0);
        check("mrst_busy", 32'(Busy), 32'd0);
        check("mrst_inready", 32'(InReady), 32'd1);
        check("mrst_result", ALUResult, 32'd0);
        spur = 0;
        repeat (40) begin
            @(negedge Clk);
            if (OutValid || Busy) spur++;
        end
        check("mrst_no_partial", 32'(spur), 32'd0);
        @(posedge Clk); #1;

        // Reset wins over a same-cycle accept.
        Reset = 1'b1; InValid = 1'b1; ALUControl = 4'd0; A = 32'd1; B = 32'd2;
        @(posedge Clk);
        #1 Reset = 1'b0; InValid = 1'b0;
        @(negedge Clk);
        check("rst_prio_valid", 32'(OutValid), 32'd0);
        check("rst_prio_result", ALUResult, 32'd0);

        // Still functional after reset.
        @(posedge Clk); #1;
        send(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'hF00F_F00F, 1'b0);
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("drain_final", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
